// File: rtl/seg7_pkg.sv
// Shared 7-segment display types and constants.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package seg7_pkg;

    localparam logic [7:0] SEG_OFF        = 8'hFF;
    localparam int         NIBBLE_W       = 4;
    // Board pins for all display blocks sink current: a 0 lights the segment.
    localparam bit         SEG_ACTIVE_LOW = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GUARD,
        ST_DRIVE
    } scan_state_t;

    function automatic logic [7:0] seg_pins(input logic dp, input logic [6:0] seg);
        return SEG_ACTIVE_LOW ? ~{dp, seg} : {dp, seg};
    endfunction

endpackage

// File: rtl/seg7enc.sv
// Hex nibble to active-high segment pattern {g,f,e,d,c,b,a}.
// Latency: combinational.
// Backpressure: none.
module seg7enc (
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h00;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/seg7scan.sv
// Self-scanning common-anode multi-digit 7-segment driver with guard blanking.
// Latency: outputs registered, 1 cycle behind scan state; LOAD visible after next frame boundary.
// Backpressure: none; LOAD accepted every cycle, last write before a boundary wins.
// SEG7SCAN_LZB_EN enables leading-zero blanking.
module seg7scan
    import seg7_pkg::*;
#(
    parameter int N_DIGIT = 4,
    parameter int DIV     = 50000,
    parameter int GUARD   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          load,
    input  logic [NIBBLE_W*N_DIGIT-1:0]   data_i,
    input  logic [N_DIGIT-1:0]            dp_i,
    output logic [7:0]                    seg_o,
    output logic [N_DIGIT-1:0]            dig_o,
    output logic                          frame_o
);

    localparam int DAT_W = NIBBLE_W * N_DIGIT;
    localparam int PRE_W = $clog2(DIV);
    localparam int IDX_W = ($clog2(N_DIGIT) > 1) ? $clog2(N_DIGIT) : 1;

    localparam logic [PRE_W-1:0] PRE_GLAST = PRE_W'(GUARD - 1);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGIT - 1);

    if (GUARD < 1 || GUARD >= DIV || DIV < 4 || N_DIGIT < 2 || N_DIGIT > 8) begin : g_bad_param
        $error("seg7scan: illegal parameters (need 2<=N_DIGIT<=8, DIV>=4, 1<=GUARD<DIV)");
    end

    scan_state_t        state, state_nxt;
    logic [PRE_W-1:0]   pre, pre_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic               wrap;

    logic [DAT_W-1:0]   pend_dat, disp_dat;
    logic [N_DIGIT-1:0] pend_dp, disp_dp;
    logic               pend_vld;
    logic               commit;

    logic [NIBBLE_W-1:0] cur_nib;
    logic                cur_dp;
    logic [6:0]          enc_seg;
    logic [6:0]          glyph;
    logic [7:0]          seg_nxt;
    logic [N_DIGIT-1:0]  dig_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            pre   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            pre   <= pre_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pre_nxt   = pre;
        idx_nxt   = idx;
        wrap      = 1'b0;
        if (!en) begin
            state_nxt = ST_IDLE;
            pre_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_GUARD;
                    pre_nxt   = '0;
                    idx_nxt   = '0;
                end
                ST_GUARD: begin
                    pre_nxt = pre + PRE_W'(1);
                    if (pre == PRE_GLAST) begin
                        state_nxt = ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (pre == PRE_LAST) begin
                        state_nxt = ST_GUARD;
                        pre_nxt   = '0;
                        if (idx == IDX_LAST) begin
                            idx_nxt = '0;
                            wrap    = 1'b1;
                        end else begin
                            idx_nxt = idx + IDX_W'(1);
                        end
                    end else begin
                        pre_nxt = pre + PRE_W'(1);
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    pre_nxt   = '0;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    // A dark display has no frame to tear, so IDLE also promotes pending data.
    assign commit = pend_vld && (wrap || state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_dat <= '0;
            pend_dp  <= '0;
            pend_vld <= 1'b0;
            disp_dat <= '0;
            disp_dp  <= '0;
        end else begin
            if (commit) begin
                disp_dat <= pend_dat;
                disp_dp  <= pend_dp;
            end
            if (load) begin
                pend_dat <= data_i;
                pend_dp  <= dp_i;
                pend_vld <= 1'b1;
            end else if (commit) begin
                pend_vld <= 1'b0;
            end
        end
    end

    always_comb begin
        cur_nib = '0;
        cur_dp  = 1'b0;
        for (int k = 0; k < N_DIGIT; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nib = disp_dat[k*NIBBLE_W +: NIBBLE_W];
                cur_dp  = disp_dp[k];
            end
        end
    end

    seg7enc u_enc (
        .nib (cur_nib),
        .seg (enc_seg)
    );

`ifdef SEG7SCAN_LZB_EN
    logic [N_DIGIT-1:0] lz_blank;
    logic               cur_blank;

    // Digit k blanks only when it and every more significant nibble are zero.
    always_comb begin : lz_scan
        logic run;
        run      = 1'b1;
        lz_blank = '0;
        for (int k = N_DIGIT - 1; k >= 1; k--) begin
            run         = run && (disp_dat[k*NIBBLE_W +: NIBBLE_W] == '0);
            lz_blank[k] = run;
        end
    end

    assign cur_blank = lz_blank[idx];
    assign glyph     = cur_blank ? 7'h00 : enc_seg;
`else
    assign glyph = enc_seg;
`endif

    // Gating on en makes a disable go dark on the very next cycle.
    always_comb begin
        seg_nxt = SEG_OFF;
        dig_nxt = '1;
        if (en && state == ST_DRIVE) begin
            dig_nxt = ~(N_DIGIT'(1) << idx);
            seg_nxt = seg_pins(cur_dp, glyph);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_o   <= SEG_OFF;
            dig_o   <= '1;
            frame_o <= 1'b0;
        end else begin
            seg_o   <= seg_nxt;
            dig_o   <= dig_nxt;
            frame_o <= wrap;
        end
    end

endmodule

// File: tb/tb_seg7scan.sv
// Directed bench for seg7scan with N_DIGIT=4, DIV=8, GUARD=2.
// Frame tables carry loads to inject and the expected glyph per digit.
module tb_seg7scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] data_i;
    logic [3:0]  dp_i;
    logic [7:0]  seg_o;
    logic [3:0]  dig_o;
    logic        frame_o;

    int errs   = 0;
    int checks = 0;

    seg7scan #(.N_DIGIT(4), .DIV(8), .GUARD(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .load    (load),
        .data_i  (data_i),
        .dp_i    (dp_i),
        .seg_o   (seg_o),
        .dig_o   (dig_o),
        .frame_o (frame_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exp_seg;  // digit k expected SEG_O at [8k+7:8k]
        int          l1_at;    // frame sample after which LOAD is raised (0 = none)
        logic [15:0] l1_dat;
        logic [3:0]  l1_dp;
        int          l2_at;
        logic [15:0] l2_dat;
        logic [3:0]  l2_dp;
    } frame_t;

    frame_t tbl[5];
    frame_t fz;
    frame_t flzb;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic [3:0] wd, input logic [7:0] ws, input logic wf);
        checks++;
        if (dig_o !== wd || seg_o !== ws || frame_o !== wf) begin
            errs++;
            $display("FAIL %s: got dig=%h seg=%h frame=%b, expected dig=%h seg=%h frame=%b",
                     nm, dig_o, seg_o, frame_o, wd, ws, wf);
        end
    endtask

    // Starts right after a frame boundary sample (or the enable sample) and walks 32 samples.
    task automatic run_frame(input frame_t f, input string nm);
        int d;
        int p;
        logic [3:0] wd;
        logic [7:0] ws;
        logic       wf;
        for (int j = 1; j <= 32; j++) begin
            step();
            d  = (j - 1) / 8;
            p  = (j - 1) % 8;
            wd = (p < 2) ? 4'hF : ~(4'(1) << d);
            ws = (p < 2) ? 8'hFF : f.exp_seg[8*d +: 8];
            wf = (j == 32);
            chk_out($sformatf("%s s%0d", nm, j), wd, ws, wf);
            load = 1'b0;
            if (j == f.l1_at) begin
                load = 1'b1; data_i = f.l1_dat; dp_i = f.l1_dp;
            end
            if (j == f.l2_at) begin
                load = 1'b1; data_i = f.l2_dat; dp_i = f.l2_dp;
            end
        end
    endtask

    task automatic idle_load(input logic [15:0] d, input logic [3:0] p);
        load = 1'b1; data_i = d; dp_i = p;
        step();
        load = 1'b0;
        step();
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b1;
        load   = 1'b0;
        data_i = '0;
        dp_i   = '0;

`ifdef SEG7SCAN_LZB_EN
        fz   = '{32'hFFFFFFC0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0};
        flzb = '{32'hFF7F92C0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0};
`else
        fz   = '{32'hC0C0C0C0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0};
        flzb = '{32'hC04092C0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0};
`endif
        // 1234 loaded in IDLE; ABCD mid digit 1 waits a frame.
        tbl[0] = '{32'hF9A4B099, 12, 16'hABCD, 4'h0,  0, 16'h0000, 4'h0};
        // 9876 pending when E0F1 arrives in the boundary cycle.
        tbl[1] = '{32'h8883C6A1,  5, 16'h9876, 4'h8, 31, 16'hE0F1, 4'h0};
        tbl[2] = '{32'h1080F882,  0, 16'h0000, 4'h0,  0, 16'h0000, 4'h0};
        // Two loads in one frame: the second wins.
        tbl[3] = '{32'h86C08EF9,  3, 16'h1111, 4'hF, 20, 16'h2222, 4'h0};
        tbl[4] = '{32'hA4A4A4A4,  0, 16'h0000, 4'h0,  0, 16'h0000, 4'h0};

        step();
        step();
        chk_out("reset", 4'hF, 8'hFF, 1'b0);
        rst_n = 1'b1;
        step();
        chk_out("release s0", 4'hF, 8'hFF, 1'b0);
        run_frame(fz, "zero");

        en = 1'b0;
        step();
        chk_out("disable", 4'hF, 8'hFF, 1'b0);
        idle_load(16'h1234, 4'h0);
        chk_out("idle dark", 4'hF, 8'hFF, 1'b0);
        en = 1'b1;
        step();
        chk_out("enable s0", 4'hF, 8'hFF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            run_frame(tbl[i], $sformatf("vec%0d", i));
        end

        for (int j = 1; j <= 21; j++) begin
            step();
        end
        chk_out("digit2 lit", 4'hB, 8'hA4, 1'b0);
        en = 1'b0;
        step();
        chk_out("en drop", 4'hF, 8'hFF, 1'b0);
        step();
        chk_out("en low idle", 4'hF, 8'hFF, 1'b0);
        en = 1'b1;
        step();
        chk_out("reenable s0", 4'hF, 8'hFF, 1'b0);
        run_frame(tbl[4], "restart");

        en = 1'b0;
        step();
        idle_load(16'h0050, 4'b0100);
        en = 1'b1;
        step();
        chk_out("lzb s0", 4'hF, 8'hFF, 1'b0);
        run_frame(flzb, "lzb");

        for (int j = 1; j <= 4; j++) begin
            step();
        end
        chk_out("pre-reset lit", 4'hE, 8'hC0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_out("async reset", 4'hF, 8'hFF, 1'b0);
        step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
